mm_inst_scheduler: RTL and testbench
====================================

// Module: mm_inst_scheduler
// PURPOSE
//  Queues matrix-multiply instructions and sequences them one at a time into the MM engine.
//  Each instruction is decoded into the engine's start parameters and issued with a one-cycle start pulse.
//  The block then waits for the engine's done pulse, reports completion with the instruction's tag, and issues the next one.
//  Sits between the instruction dispatcher and the MM engine; also provides a dimension check, a watchdog and perf counters.
// PARAMETERS
//  FIFO_DEPTH  4        instruction queue entries (power of 2, >=2)
//  TIMEOUT     1048576  max cycles in WAIT before watchdog trips; 0 = watchdog disabled
//  TO_W        24       watchdog counter width (2^TO_W > TIMEOUT)
// PORTS
//  clk                  in   1   clock
//  rstn                 in   1   async active-low reset
//  inst_valid           in   1   instruction word valid
//  inst_ready           out  1   queue not full; a push happens when valid&ready
//  inst_data            in   96  instruction, field layout below
//  mm_start_valid       out  1   one-cycle start pulse to the MM engine
//  mm_weight_start_addr out  13  weight buffer base address
//  mm_input_start_addr  out  11  input buffer base address
//  mm_output_start_addr out  11  output buffer base address
//  mm_bias_start_addr   out  9   bias buffer base address
//  mm_ci                out  8   input addresses per feature (Ci)
//  mm_co                out  8   output addresses per feature (Co)
//  mm_n                 out  16  number of nodes (N)
//  mm_r / mm_a / mm_b   out  1   relu / accumulate / bias enables
//  mm_done              in   1   engine done pulse
//  inst_done            out  1   one-cycle completion pulse
//  inst_done_tag        out  5   tag of the completed instruction
//  inst_done_err        out  1   qualifies inst_done: 1 = instruction rejected
//  busy                 out  1   state != IDLE, or queue not empty
//  timeout_err          out  1   sticky watchdog flag
//  clr_err              in   1   clears timeout_err and releases HALT
//  perf_busy_cycles     out  32  cycles spent in START+WAIT (saturating)
//  perf_inst_count      out  16  instructions completed OK (wraps)
// BEHAVIOUR
//  Field layout
//   [12:0]  weight addr     [23:13] input addr    [34:24] output addr
//   [43:35] bias addr       [51:44] Ci            [59:52] Co
//   [75:60] N               [76] r   [77] a   [78] b
//   [83:79] tag             [95:84] reserved, ignored
//  Reset values
//   All registered outputs, counters, FSM (IDLE) and queue pointers are 0.
//   inst_ready is combinational (count<FIFO_DEPTH), so it reads 1 after reset.
//  Queue
//   Push and pop in the same cycle are legal, including when full (ready=0 blocks the push only).
//   Pointers wrap modulo FIFO_DEPTH.
//   Contents are preserved in HALT; pushes are still accepted while not full.
//  FSM states: IDLE, START, WAIT, DONE, HALT
//   IDLE, queue non-empty, head has Ci, Co and N all !=0:
//    - pop; load all mm_* parameter registers from the head; -> START.
//   IDLE, queue non-empty, any of Ci/Co/N ==0:
//    - pop; next cycle inst_done=1, inst_done_err=1, tag = head tag; stay IDLE.
//    - The engine is not started.
//   START: mm_start_valid=1 for exactly this cycle; watchdog cleared; -> WAIT.
//   WAIT: watchdog increments each cycle.
//    - mm_done=1 -> DONE. mm_done wins if it coincides with watchdog expiry.
//    - TIMEOUT!=0 and count==TIMEOUT-1 without mm_done -> timeout_err=1, -> HALT.
//   DONE: inst_done=1, inst_done_err=0, tag = current; perf_inst_count+1; -> IDLE.
//   HALT: no issue; mm_done is ignored. clr_err=1 -> timeout_err=0, -> IDLE.
//  Timing
//   Issue latency: push at edge E0 into an empty queue with FSM IDLE.
//    - E1 loads parameters; mm_start_valid is high E1..E2.
//   Back-to-back: mm_done in cycle D gives DONE in D+1, IDLE in D+2, START in D+3.
//    - This guarantees >=2 idle cycles between the engine's done and the next start.
//   mm_* parameter outputs stay stable from load until the next load. They never change during WAIT.
//   Spurious mm_done in IDLE, START or DONE is ignored.
//   perf_busy_cycles saturates at 0xFFFFFFFF.
//  Reset mid-operation: everything returns to reset values immediately. Queued instructions are lost.
// TESTING
//  1 Single instr (Ci=2,Co=3,N=4,tag=5), mm_done 30 cycles after start
//    -> one start pulse 1 cycle after push; inst_done tag=5 err=0; perf_inst_count=1.
//  2 Push 5 instrs back-to-back, DEPTH=4, engine busy
//    -> inst_ready drops after 4th (or 5th if pop same cycle); all 5 done in order; start >=3 cycles after each mm_done.
//  3 Instr with Co=0 between two valid ones
//    -> err done for middle tag, no start pulse for it; neighbours complete normally.
//  4 TIMEOUT=100, mm_done withheld
//    -> timeout_err=1 after 100 WAIT cycles, no further starts; clr_err -> next queued instr starts.
//  5 mm_done on same cycle as watchdog expiry -> normal DONE, timeout_err stays 0.
//  6 rstn low during WAIT with 3 queued
//    -> all outputs 0, inst_ready=1, busy=0; after release no start until a new push.

Source files
------------

// File: rtl/mm_inst_scheduler_if.sv
// -----------------------------------------------------------------------------
// mm_inst_scheduler_if
//   Instruction channel between the dispatcher and mm_inst_scheduler: the
//   valid/ready push of 96-bit instruction words and the completion report
//   that comes back.
//
//   inst_valid     dispatcher -> scheduler  instruction word valid
//   inst_ready     scheduler -> dispatcher  queue has room
//   inst_data      dispatcher -> scheduler  96-bit instruction word
//   inst_done      scheduler -> dispatcher  one-cycle completion pulse
//   inst_done_tag  scheduler -> dispatcher  tag of the completed instruction
//   inst_done_err  scheduler -> dispatcher  1 = instruction was rejected
//
//   master: dispatcher side, slave: scheduler side.
// -----------------------------------------------------------------------------
interface mm_inst_scheduler_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [95:0] inst_data;
    logic        inst_done;
    logic [4:0]  inst_done_tag;
    logic        inst_done_err;

    modport master (
        output inst_valid, inst_data,
        input  inst_ready, inst_done, inst_done_tag, inst_done_err
    );

    modport slave (
        input  inst_valid, inst_data,
        output inst_ready, inst_done, inst_done_tag, inst_done_err
    );
endinterface

// File: rtl/mm_inst_scheduler.sv
// -----------------------------------------------------------------------------
// mm_inst_scheduler
//   Queues matrix-multiply instructions and issues them one at a time to the
//   MM engine. Each accepted instruction is decoded into the engine's start
//   parameters, launched with a one-cycle start pulse, and retired when the
//   engine pulses done. Instructions with a zero Ci, Co or N are rejected
//   without starting the engine. A watchdog halts issue if the engine never
//   answers; clr_err releases the halt.
//
//   clk, rstn             clock, async active-low reset
//   inst                  instruction channel (push + completion report)
//   mm_start_valid        one-cycle engine start pulse
//   mm_*_start_addr       weight / input / output / bias base addresses
//   mm_ci, mm_co, mm_n    Ci, Co, N of the issued instruction
//   mm_r, mm_a, mm_b      relu / accumulate / bias enables
//   mm_done               engine done pulse
//   busy                  FSM not idle or queue not empty
//   timeout_err, clr_err  sticky watchdog flag and its clear
//   perf_busy_cycles      cycles in START+WAIT, saturating
//   perf_inst_count       instructions completed successfully, wrapping
// -----------------------------------------------------------------------------
module mm_inst_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1048576,
    parameter int TO_W       = 24
) (
    input  logic                   clk,
    input  logic                   rstn,
    mm_inst_scheduler_if.slave     inst,
    output logic                   mm_start_valid,
    output logic [12:0]            mm_weight_start_addr,
    output logic [10:0]            mm_input_start_addr,
    output logic [10:0]            mm_output_start_addr,
    output logic [8:0]             mm_bias_start_addr,
    output logic [7:0]             mm_ci,
    output logic [7:0]             mm_co,
    output logic [15:0]            mm_n,
    output logic                   mm_r,
    output logic                   mm_a,
    output logic                   mm_b,
    input  logic                   mm_done,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   clr_err,
    output logic [31:0]            perf_busy_cycles,
    output logic [15:0]            perf_inst_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    // Last WAIT cycle index before the watchdog trips.
    localparam logic [TO_W-1:0] WD_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    // ---------------------------------------------------------------- queue
    // Only bits [83:0] carry information; the reserved top bits are dropped.
    logic [83:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop, empty;
    logic [83:0]      head;
    logic             head_ok;
    logic             load, reject;
    logic             unused_rsvd;

    assign unused_rsvd    = ^inst.inst_data[95:84];
    assign inst.inst_ready = (count != CNT_FULL);
    assign push           = inst.inst_valid && inst.inst_ready;
    assign empty          = (count == '0);
    assign head           = mem[rd_ptr];
    assign head_ok        = (head[51:44] != '0) && (head[59:52] != '0) && (head[75:60] != '0);

    // NOTE: queue storage has no reset; the pointers and count alone define
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= inst.inst_data[83:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------ FSM
    logic [TO_W-1:0] wd_cnt;
    logic            wd_expire;

    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        reject    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        load      = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        reject    = 1'b1;
                    end
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                // A done that coincides with watchdog expiry still completes.
                if (mm_done)        state_nxt = S_DONE;
                else if (wd_expire) state_nxt = S_HALT;
            end
            S_DONE: state_nxt = S_IDLE;
            S_HALT: if (clr_err) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mm_start_valid = (state == S_START);
    assign busy           = (state != S_IDLE) || !empty;

    // ------------------------------------------------------------- datapath
    logic [4:0] cur_tag;
    logic       done_q, done_err_q;
    logic [4:0] done_tag_q;

    assign inst.inst_done     = done_q;
    assign inst.inst_done_tag = done_tag_q;
    assign inst.inst_done_err = done_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mm_weight_start_addr <= '0;
            mm_input_start_addr  <= '0;
            mm_output_start_addr <= '0;
            mm_bias_start_addr   <= '0;
            mm_ci                <= '0;
            mm_co                <= '0;
            mm_n                 <= '0;
            mm_r                 <= 1'b0;
            mm_a                 <= 1'b0;
            mm_b                 <= 1'b0;
            cur_tag              <= '0;
            wd_cnt               <= '0;
            done_q               <= 1'b0;
            done_err_q           <= 1'b0;
            done_tag_q           <= '0;
            timeout_err          <= 1'b0;
            perf_busy_cycles     <= '0;
            perf_inst_count      <= '0;
        end else begin
            // Parameters change only here, so they hold through WAIT.
            if (load) begin
                mm_weight_start_addr <= head[12:0];
                mm_input_start_addr  <= head[23:13];
                mm_output_start_addr <= head[34:24];
                mm_bias_start_addr   <= head[43:35];
                mm_ci                <= head[51:44];
                mm_co                <= head[59:52];
                mm_n                 <= head[75:60];
                mm_r                 <= head[76];
                mm_a                 <= head[77];
                mm_b                 <= head[78];
                cur_tag              <= head[83:79];
            end

            if (state == S_START)     wd_cnt <= '0;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + TO_W'(1);

            // Completion report lands in the cycle after the deciding edge:
            // the DONE cycle for normal completion, IDLE+1 for a reject.
            done_q <= 1'b0;
            if (reject) begin
                done_q     <= 1'b1;
                done_err_q <= 1'b1;
                done_tag_q <= head[83:79];
            end else if (state == S_WAIT && state_nxt == S_DONE) begin
                done_q     <= 1'b1;
                done_err_q <= 1'b0;
                done_tag_q <= cur_tag;
            end

            if (state == S_WAIT && state_nxt == S_HALT) timeout_err <= 1'b1;
            else if (clr_err)                          timeout_err <= 1'b0;

            if ((state == S_START || state == S_WAIT) && perf_busy_cycles != '1) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end

            if (state == S_DONE) perf_inst_count <= perf_inst_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mm_inst_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mm_inst_scheduler
//   Randomised and directed stimulus against a queue-based reference model.
//   Each pushed instruction decides, from its fields and the engine latency
//   chosen for it, whether it starts the engine and how it completes; those
//   expectations go into queues that an independent monitor consumes.
// -----------------------------------------------------------------------------
module tb_mm_inst_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;
    localparam int TOW   = 8;

    typedef struct packed {
        logic [12:0] w;
        logic [10:0] i;
        logic [10:0] o;
        logic [8:0]  b;
        logic [7:0]  ci;
        logic [7:0]  co;
        logic [15:0] n;
        logic        r;
        logic        a;
        logic        bb;
    } params_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mm_inst_scheduler_if bus();

    logic        mm_start_valid;
    logic [12:0] mm_weight_start_addr;
    logic [10:0] mm_input_start_addr;
    logic [10:0] mm_output_start_addr;
    logic [8:0]  mm_bias_start_addr;
    logic [7:0]  mm_ci, mm_co;
    logic [15:0] mm_n;
    logic        mm_r, mm_a, mm_b;
    logic        mm_done = 1'b0;
    logic        busy, timeout_err;
    logic        clr_err = 1'b0;
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_inst_count;

    mm_inst_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .TO_W(TOW)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .inst                 (bus),
        .mm_start_valid       (mm_start_valid),
        .mm_weight_start_addr (mm_weight_start_addr),
        .mm_input_start_addr  (mm_input_start_addr),
        .mm_output_start_addr (mm_output_start_addr),
        .mm_bias_start_addr   (mm_bias_start_addr),
        .mm_ci                (mm_ci),
        .mm_co                (mm_co),
        .mm_n                 (mm_n),
        .mm_r                 (mm_r),
        .mm_a                 (mm_a),
        .mm_b                 (mm_b),
        .mm_done              (mm_done),
        .busy                 (busy),
        .timeout_err          (timeout_err),
        .clr_err              (clr_err),
        .perf_busy_cycles     (perf_busy_cycles),
        .perf_inst_count      (perf_inst_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    params_t     exp_start[$];
    logic [5:0]  exp_done[$];     // {err, tag}
    int          eng_q[$];        // engine latency per started instruction, -1 = never
    int          exp_ok = 0;
    longint      exp_busy = 0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int start_cnt = 0;
    int last_start_cyc = 0;
    int last_done_cyc = -100;
    int eng_cnt = 0;
    bit spur_req = 1'b0;

    // ------------------------------------------------------- engine model
    always @(negedge clk) begin
        mm_done = 1'b0;
        if (!rstn) begin
            eng_cnt = 0;
        end else begin
            if (spur_req) begin
                mm_done  = 1'b1;
                spur_req = 1'b0;
            end
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    mm_done       = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            if (mm_start_valid && eng_q.size() > 0) begin
                int d;
                d = eng_q.pop_front();
                eng_cnt = (d > 0) ? d : 0;
            end
        end
    end

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rstn) begin
            if (mm_start_valid) begin
                start_cnt++;
                last_start_cyc = cyc;
                if (exp_start.size() == 0) begin
                    check("unexpected_start", 128'(1), 128'(0));
                end else begin
                    check("start_params",
                          128'({mm_weight_start_addr, mm_input_start_addr, mm_output_start_addr,
                                mm_bias_start_addr, mm_ci, mm_co, mm_n, mm_r, mm_a, mm_b}),
                          128'(exp_start.pop_front()));
                end
                check("start_gap_after_done", 128'((cyc - last_done_cyc) >= 3), 128'(1));
            end
            if (bus.inst_done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 128'({bus.inst_done_err, bus.inst_done_tag}), 128'(6'h3f));
                end else begin
                    check("done_err_tag", 128'({bus.inst_done_err, bus.inst_done_tag}),
                          128'(exp_done.pop_front()));
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    function automatic params_t rand_params(input bit allow_zero);
        params_t p;
        p.w  = 13'($urandom);
        p.i  = 11'($urandom);
        p.o  = 11'($urandom);
        p.b  = 9'($urandom);
        p.ci = 8'($urandom_range(1, 255));
        p.co = 8'($urandom_range(1, 255));
        p.n  = 16'($urandom_range(1, 65535));
        p.r  = 1'($urandom);
        p.a  = 1'($urandom);
        p.bb = 1'($urandom);
        if (allow_zero && $urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 2))
                0:       p.ci = '0;
                1:       p.co = '0;
                default: p.n  = '0;
            endcase
        end
        return p;
    endfunction

    function automatic params_t mk(input int ci, input int co, input int n);
        params_t p;
        p    = rand_params(1'b0);
        p.ci = 8'(ci);
        p.co = 8'(co);
        p.n  = 16'(n);
        return p;
    endfunction

    // Called at a negedge; returns at the negedge after the push edge with
    // inst_valid still high so pushes can run back to back.
    task automatic push_inst(input params_t p, input logic [4:0] tag, input int delay);
        int k;
        bus.inst_valid = 1'b1;
        bus.inst_data  = {12'($urandom), tag, p.bb, p.a, p.r, p.n, p.co, p.ci, p.b, p.o, p.i, p.w};
        k = 0;
        while (!bus.inst_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            check("push_ready_timeout", 128'(0), 128'(1));
        end else begin
            if (p.ci == 0 || p.co == 0 || p.n == 0) begin
                exp_done.push_back({1'b1, tag});
            end else begin
                exp_start.push_back(p);
                eng_q.push_back(delay);
                if (delay >= 1 && delay <= TMO) begin
                    exp_done.push_back({1'b0, tag});
                    exp_ok++;
                    exp_busy += longint'(1 + delay);
                end else begin
                    exp_busy += longint'(1 + TMO);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || exp_done.size() != 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check({name, "_drained"}, 128'(k < 5000), 128'(1));
        check({name, "_pending_starts"}, 128'(exp_start.size()), 128'(0));
        check({name, "_inst_count"}, 128'(perf_inst_count), 128'(16'(exp_ok)));
        check({name, "_busy_cycles"}, 128'(perf_busy_cycles), 128'(32'(exp_busy)));
    endtask

    task automatic wait_start(input int prev);
        int k;
        k = 0;
        while (start_cnt == prev && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("start_seen", 128'(start_cnt > prev), 128'(1));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_params"},
              128'({mm_weight_start_addr, mm_input_start_addr, mm_output_start_addr,
                    mm_bias_start_addr, mm_ci, mm_co, mm_n, mm_r, mm_a, mm_b}), 128'(0));
        check({name, "_status"},
              128'({mm_start_valid, bus.inst_done, bus.inst_done_tag, bus.inst_done_err,
                    busy, timeout_err, perf_busy_cycles, perf_inst_count}), 128'(0));
        check({name, "_ready"}, 128'(bus.inst_ready), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int p_cyc, s0, s_cyc, k, err_cyc;
        bus.inst_valid = 1'b0;
        bus.inst_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        // 1: single instruction, engine answers 30 cycles after start
        p_cyc = cyc;
        push_inst(mk(2, 3, 4), 5'd5, 30);
        bus.inst_valid = 1'b0;
        wait_start(0);
        check("issue_latency", 128'(last_start_cyc), 128'(p_cyc + 2));
        wait_idle("single");
        check("single_count_is_1", 128'(perf_inst_count), 128'(1));

        // 2: five back-to-back pushes while the engine is busy
        push_inst(mk(1, 2, 3), 5'd10, 40);
        push_inst(mk(5, 6, 7), 5'd11, 10);
        push_inst(mk(8, 9, 10), 5'd12, 5);
        push_inst(mk(11, 12, 13), 5'd13, 1);
        push_inst(mk(14, 15, 16), 5'd14, 20);
        check("full_ready_low", 128'(bus.inst_ready), 128'(0));
        bus.inst_valid = 1'b0;
        wait_idle("burst");

        // 3: Co=0 between two valid instructions
        s0 = start_cnt;
        push_inst(mk(1, 1, 1), 5'd20, 8);
        push_inst(mk(3, 0, 5), 5'd21, 8);
        push_inst(mk(4, 4, 4), 5'd22, 6);
        bus.inst_valid = 1'b0;
        wait_idle("reject");
        check("reject_start_count", 128'(start_cnt - s0), 128'(2));

        // 4: engine never answers; watchdog halts issue until clr_err
        s0 = start_cnt;
        push_inst(mk(7, 7, 7), 5'd23, -1);
        push_inst(mk(9, 9, 9), 5'd24, 12);
        bus.inst_valid = 1'b0;
        wait_start(s0);
        s_cyc = last_start_cyc;
        k = 0;
        while (!timeout_err && k < 400) begin
            @(negedge clk);
            k++;
        end
        err_cyc = cyc;
        check("timeout_raised", 128'(timeout_err), 128'(1));
        check("timeout_cycle", 128'(err_cyc), 128'(s_cyc + TMO + 1));
        spur_req = 1'b1;
        repeat (20) @(negedge clk);
        check("halt_no_start", 128'(start_cnt - s0), 128'(1));
        check("halt_busy", 128'(busy), 128'(1));
        check("halt_err_sticky", 128'(timeout_err), 128'(1));
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err_clears", 128'(timeout_err), 128'(0));
        wait_idle("timeout");
        check("timeout_then_start", 128'(start_cnt - s0), 128'(2));

        // 5: done on the watchdog's last cycle completes normally
        push_inst(mk(2, 2, 2), 5'd25, TMO);
        bus.inst_valid = 1'b0;
        wait_idle("edge_done");
        check("edge_no_timeout", 128'(timeout_err), 128'(0));

        // Spurious mm_done while idle is ignored
        s0 = start_cnt;
        spur_req = 1'b1;
        repeat (5) @(negedge clk);
        check("spurious_no_start", 128'(start_cnt), 128'(s0));
        check("spurious_idle", 128'(busy), 128'(0));
        check("spurious_count", 128'(perf_inst_count), 128'(16'(exp_ok)));

        // Randomised traffic
        for (int t = 0; t < 30; t++) begin
            int d;
            d = ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(1, 40));
            push_inst(rand_params(1'b1), 5'($urandom), d);
            if ($urandom_range(0, 1) == 1) begin
                bus.inst_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.inst_valid = 1'b0;
        wait_idle("random");

        // 6: reset during WAIT with three instructions queued
        s0 = start_cnt;
        for (int t = 0; t < 4; t++) push_inst(mk(3, 3, 3), 5'(t + 1), 90);
        bus.inst_valid = 1'b0;
        wait_start(s0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        exp_start.delete();
        exp_done.delete();
        eng_q.delete();
        exp_ok = 0;
        exp_busy = 0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        s0 = start_cnt;
        repeat (10) @(negedge clk);
        check("post_reset_no_start", 128'(start_cnt), 128'(s0));
        check("post_reset_idle", 128'(busy), 128'(0));
        push_inst(mk(6, 5, 4), 5'd30, 7);
        bus.inst_valid = 1'b0;
        wait_idle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
